// File: rtl/ext_code_pkg.sv
// Shared defaults and the sequencer state type for the external channel-code player.
// Pure declarations; no logic, so no latency or backpressure.
package ext_code_pkg;

  localparam int CODE_W_DEF      = 32;
  localparam int DEPTH_DEF       = 8;
  localparam int IDX_W_DEF       = $clog2(DEPTH_DEF);
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // ARMED and ACTIVE are the states in which the table is being played and must not change.
  function automatic logic is_armed(input state_e s);
    return (s == ARMED) || (s == ACTIVE);
  endfunction

endpackage

// File: rtl/ext_code_sequencer_if.sv
// Host/channel bundle for the code sequencer: table writes, arm/abort, trigger in, code out.
// Wires only; the master side drives requests, the slave side (the sequencer) answers.
interface ext_code_sequencer_if
  import ext_code_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
);

  logic              iWr_en;
  logic [IDX_W-1:0]  iWr_addr;
  logic [CODE_W-1:0] iWr_data;
  logic [IDX_W-1:0]  iStart_idx;
  logic              iArm;
  logic              iAbort;
  logic              iTrigger;
  logic [CODE_W-1:0] oCode;
  logic [IDX_W-1:0]  oIndex;
  logic              oArmed;
  logic              oDone;
  logic              oWr_err;
  logic              oTrig_ovr;

  modport master (
    output iWr_en, iWr_addr, iWr_data, iStart_idx, iArm, iAbort, iTrigger,
    input  oCode, oIndex, oArmed, oDone, oWr_err, oTrig_ovr
  );

  modport slave (
    input  iWr_en, iWr_addr, iWr_data, iStart_idx, iArm, iAbort, iTrigger,
    output oCode, oIndex, oArmed, oDone, oWr_err, oTrig_ovr
  );

endinterface

// File: rtl/ext_code_trig_sync.sv
// Brings the asynchronous trigger into iClk and flags its edges; level after SYNC_STAGES-1
// edges, rise/fall one cycle wide and combinational off the last stage. No backpressure.
module ext_code_trig_sync
  import ext_code_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iTrigger,
  output logic oLevel,
  output logic oRise,
  output logic oFall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d1_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_q   <= '0;
      lvl_d1_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], iTrigger};
      lvl_d1_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign oLevel = sync_q[SYNC_STAGES-1];
  assign oRise  = oLevel & ~lvl_d1_q;
  assign oFall  = ~oLevel & lvl_d1_q;

endmodule

// File: rtl/ext_code_sequencer.sv
// Plays an 8x32 code table, one entry per trigger pulse, counting down to entry 0; oCode moves
// SYNC_STAGES edges after the trigger is sampled. No backpressure. Optional macro EXT_CODE_LOOP_EN.
module ext_code_sequencer
  import ext_code_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  ext_code_sequencer_if.slave   bus
);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CODE_W-1:0] code_q;
  logic              done_q;
  logic              wr_err_q;
  logic              trig_ovr_q;
  logic [CODE_W-1:0] table_q [DEPTH];
`ifdef EXT_CODE_LOOP_EN
  logic [IDX_W-1:0]  start_q;
`endif

  logic trig_lvl_unused;
  logic trig_rise;
  logic trig_fall;

  ext_code_trig_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iTrigger (bus.iTrigger),
    .oLevel   (trig_lvl_unused),
    .oRise    (trig_rise),
    .oFall    (trig_fall)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      code_q     <= '0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      trig_ovr_q <= 1'b0;
`ifdef EXT_CODE_LOOP_EN
      start_q    <= '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
        table_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      // The table is frozen while a sequence is in flight; a late write is flagged, not applied.
      if (bus.iWr_en) begin
        if (is_armed(state_q)) begin
          wr_err_q <= 1'b1;
        end else begin
          table_q[bus.iWr_addr] <= bus.iWr_data;
        end
      end

      if (bus.iAbort) begin
        state_q <= IDLE;
        code_q  <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (trig_rise) begin
              trig_ovr_q <= 1'b1;
            end
            if (bus.iArm) begin
              idx_q      <= bus.iStart_idx;
`ifdef EXT_CODE_LOOP_EN
              start_q    <= bus.iStart_idx;
`endif
              wr_err_q   <= 1'b0;
              trig_ovr_q <= 1'b0;
              state_q    <= ARMED;
            end
          end
          ARMED: begin
            if (trig_rise) begin
              code_q  <= table_q[idx_q];
              state_q <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (trig_fall) begin
              code_q <= '0;
              if (idx_q == '0) begin
                done_q  <= 1'b1;
`ifdef EXT_CODE_LOOP_EN
                idx_q   <= start_q;
                state_q <= ARMED;
`else
                state_q <= DONE;
`endif
              end else begin
                idx_q   <= idx_q - IDX_W'(1);
                state_q <= ARMED;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.oCode     = code_q;
  assign bus.oIndex    = idx_q;
  assign bus.oArmed    = is_armed(state_q);
  assign bus.oDone     = done_q;
  assign bus.oWr_err   = wr_err_q;
  assign bus.oTrig_ovr = trig_ovr_q;

endmodule

// File: tb/tb_ext_code_sequencer.sv
// Directed-plus-random bench: a queue-of-entries model predicts every code, index and flag.
module tb_ext_code_sequencer;
  import ext_code_pkg::*;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;

  ext_code_sequencer_if bus_if ();

  ext_code_sequencer dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus_if)
  );

  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the table, the list of entries still to be played, and the sticky flags.
  logic [31:0] m_tab [8];
  int          m_q[$];
  bit          m_armed;
  int          m_start;
  int          m_index;
  bit          m_wr_err;
  bit          m_ovr;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_tab[k] = '0;
    m_q.delete();
    m_armed  = 0;
    m_start  = 0;
    m_index  = 0;
    m_wr_err = 0;
    m_ovr    = 0;
  endtask

  task automatic m_load_pass();
    m_q.delete();
    for (int k = m_start; k >= 0; k--) m_q.push_back(k);
    m_index = m_start;
  endtask

  task automatic m_write(input int a, input logic [31:0] d);
    if (m_armed) m_wr_err = 1;
    else         m_tab[a] = d;
  endtask

  task automatic m_arm(input int s);
    if (!m_armed) begin
      m_start  = s;
      m_load_pass();
      m_armed  = 1;
      m_wr_err = 0;
      m_ovr    = 0;
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_armed"},  32'(bus_if.oArmed),    32'(m_armed));
    chk({tag, "_index"},  32'(bus_if.oIndex),    32'(m_index));
    chk({tag, "_wr_err"}, 32'(bus_if.oWr_err),   32'(m_wr_err));
    chk({tag, "_ovr"},    32'(bus_if.oTrig_ovr), 32'(m_ovr));
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    bus_if.iWr_en   = 1'b1;
    bus_if.iWr_addr = 3'(a);
    bus_if.iWr_data = d;
    m_write(a, d);
    tick();
    bus_if.iWr_en = 1'b0;
    chk("write_err", 32'(bus_if.oWr_err), 32'(m_wr_err));
  endtask

  task automatic do_arm(input int s, input bit with_wr, input int a, input logic [31:0] d);
    bus_if.iArm       = 1'b1;
    bus_if.iStart_idx = 3'(s);
    if (with_wr) begin
      bus_if.iWr_en   = 1'b1;
      bus_if.iWr_addr = 3'(a);
      bus_if.iWr_data = d;
      m_write(a, d);
    end
    m_arm(s);
    tick();
    bus_if.iArm   = 1'b0;
    bus_if.iWr_en = 1'b0;
    chk_flags("arm");
  endtask

  task automatic do_abort();
    bus_if.iAbort = 1'b1;
    m_armed = 0;
    m_q.delete();
    tick();
    bus_if.iAbort = 1'b0;
    chk("abort_code", bus_if.oCode, 32'h0);
    chk_flags("abort");
  endtask

  // One trigger pulse, hi cycles high (>=3) then at least 3 low; checks the two-edge latency both ways.
  task automatic pulse(input int hi, input int lo);
    logic [31:0] exp;
    int          idx;
    bit          active;
    bit          exp_done;
    active   = m_armed;
    exp_done = 0;
    if (active) begin
      idx = m_q.pop_front();
      exp = m_tab[idx];
    end else begin
      idx = m_index;
      exp = '0;
    end
    bus_if.iTrigger = 1'b1;
    tick();
    chk("rise_N", bus_if.oCode, 32'h0);
    tick();
    chk("rise_N1", bus_if.oCode, 32'h0);
    tick();
    chk("rise_N2", bus_if.oCode, exp);
    chk("rise_idx", 32'(bus_if.oIndex), 32'(idx));
    repeat (hi - 3) tick();
    bus_if.iTrigger = 1'b0;
    tick();
    chk("fall_M", bus_if.oCode, exp);
    tick();
    chk("fall_M1", bus_if.oCode, exp);
    chk("fall_M1_done", 32'(bus_if.oDone), 32'h0);
    if (active) begin
      if (m_q.size() == 0) begin
        exp_done = 1;
`ifdef EXT_CODE_LOOP_EN
        m_load_pass();
`else
        m_armed = 0;
`endif
      end else begin
        m_index = m_q[0];
      end
    end else begin
      m_ovr = 1;
    end
    tick();
    chk("fall_M2", bus_if.oCode, 32'h0);
    chk("fall_M2_done", 32'(bus_if.oDone), 32'(exp_done));
    chk_flags("fall");
    tick();
    chk("done_width", 32'(bus_if.oDone), 32'h0);
    repeat (lo) tick();
  endtask

  task automatic play(input int n);
    for (int p = 0; p < n; p++) pulse($urandom_range(3, 6), $urandom_range(0, 3));
  endtask

  initial begin
    bus_if.iWr_en     = 1'b0;
    bus_if.iWr_addr   = '0;
    bus_if.iWr_data   = '0;
    bus_if.iStart_idx = '0;
    bus_if.iArm       = 1'b0;
    bus_if.iAbort     = 1'b0;
    bus_if.iTrigger   = 1'b0;
    m_reset();
    repeat (3) tick();
    chk("rst_code", bus_if.oCode, 32'h0);
    chk("rst_done", 32'(bus_if.oDone), 32'h0);
    chk_flags("rst");
    iRst_n = 1'b1;
    tick();

    // Fixed table, start 3, four pulses down to entry 0.
    for (int k = 0; k < 8; k++) do_write(k, 32'hA000_0000 | 32'(k));
    do_arm(3, 0, 0, '0);
    play(4);
    if (m_armed) do_abort();

    // Write while armed is dropped and flagged; arm while armed is ignored.
    do_arm(5, 0, 0, '0);
    do_write(2, $urandom());
    do_arm(0, 0, 0, '0);
    play(6);
    if (m_armed) do_abort();
    do_arm(1, 0, 0, '0);
    play(2);
    if (m_armed) do_abort();

    // Abort mid-pulse, then stray triggers while idle.
    do_arm(4, 0, 0, '0);
    bus_if.iTrigger = 1'b1;
    repeat (3) tick();
    chk("abort_pre", bus_if.oCode, m_tab[4]);
    do_abort();
    bus_if.iTrigger = 1'b0;
    repeat (4) tick();
    chk("abort_post", bus_if.oCode, 32'h0);
    play(2);

    // Randomised passes, sometimes with a write landing on the arm cycle.
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 4; w++) do_write($urandom_range(0, 7), $urandom());
      do_arm($urandom_range(0, 7), it[0], $urandom_range(0, 7), $urandom());
      if (it == 2) do_write($urandom_range(0, 7), $urandom());
      play(m_start + 1);
      if (m_armed) do_abort();
      if (it == 4) play(1);
    end

`ifdef EXT_CODE_LOOP_EN
    do_arm(1, 0, 0, '0);
    play(5);
    do_abort();
`endif

    // Reset mid-pulse clears outputs immediately and empties the table.
    do_write(7, 32'hDEAD_BEEF);
    do_arm(7, 0, 0, '0);
    bus_if.iTrigger = 1'b1;
    repeat (3) tick();
    chk("rstmid_pre", bus_if.oCode, 32'hDEAD_BEEF);
    iRst_n = 1'b0;
    #1;
    chk("rstmid_code", bus_if.oCode, 32'h0);
    chk("rstmid_armed", 32'(bus_if.oArmed), 32'h0);
    bus_if.iTrigger = 1'b0;
    m_reset();
    repeat (3) tick();
    iRst_n = 1'b1;
    tick();
    do_arm(7, 0, 0, '0);
    play(8);
    if (m_armed) do_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_code_sequencer.md
Name: ext_code_sequencer

Overview:
Synchronous controller that owns an 8-entry × 32-bit channel-code table and plays it out on an external trigger. Each trigger pulse presents one entry while the trigger is high, stepping down from a host-programmed start index to entry 0. It sits between the host register interface and the 32 output channels of the pulse-timing controller, and replaces free-running trigger-clocked index logic with a single-clock state machine.

Parameters:
CODE_W, 32, width of one code word (one bit per output channel)
DEPTH, 8, number of table entries
IDX_W, 3, index width; must equal clog2(DEPTH)
SYNC_STAGES, 2, flip-flop stages synchronizing iTrigger (minimum 2)

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iWr_en  in  1  table write strobe, 1 cycle
iWr_addr  in  IDX_W  table write address
iWr_data  in  CODE_W  table write data
iStart_idx  in  IDX_W  first entry played; sampled on iArm
iArm  in  1  arm request, 1-cycle pulse
iAbort  in  1  abort request, 1-cycle pulse
iTrigger  in  1  external trigger, asynchronous to iClk
oCode  out  CODE_W  channel code; zero when not presenting
oIndex  out  IDX_W  current entry index
oArmed  out  1  high in ARMED or ACTIVE
oDone  out  1  1-cycle pulse on sequence completion
oWr_err  out  1  sticky: write attempted while oArmed
oTrig_ovr  out  1  sticky: trigger rise seen in IDLE or DONE

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, every table entry=0, oCode=0, oIndex=0, oDone=0, oWr_err=0, oTrig_ovr=0, synchronizer flops=0.
- iTrigger passes through SYNC_STAGES flops. rise/fall = synchronized level XOR its 1-cycle-delayed copy.
- Latency: N is the first iClk edge that samples iTrigger high. oCode updates at edge N+SYNC_STAGES. The fall path has the same latency.
- States:
  - IDLE: iArm loads index ← iStart_idx, goes to ARMED.
  - ARMED: rise registers oCode ← table[index], goes to ACTIVE.
  - ACTIVE: fall sets oCode ← 0. If index==0, go to DONE with oDone=1 for 1 cycle. Otherwise index ← index−1, back to ARMED.
  - DONE: behaves like IDLE. iArm re-arms.
- iAbort from any state: IDLE on the next edge, oCode ← 0, index unchanged. iAbort beats iArm and beats any trigger edge in the same cycle.
- iArm while in ARMED or ACTIVE: ignored.
- Writes:
  - In IDLE or DONE, table[iWr_addr] ← iWr_data.
  - In ARMED or ACTIVE, the write is dropped and oWr_err is set. oWr_err clears only on reset or an accepted iArm.
  - Write and iArm in the same cycle (IDLE): both take effect; the new data is visible to the first trigger.
- A rise in IDLE or DONE is ignored and sets oTrig_ovr. oTrig_ovr clears on reset or an accepted iArm.
- Rise and fall both detected in one cycle cannot happen with SYNC_STAGES≥2, because a pulse shorter than one cycle produces at most one edge per cycle. A pulse shorter than one iClk period may be missed; this is accepted behaviour.
- oCode is a registered output.
- oIndex shows the live index: the start value after arm, then the decremented value.

Optional Feature:
EXT_CODE_LOOP_EN
- Defined: an ACTIVE fall at index 0 pulses oDone, reloads index ← the start index latched at the last arm, and returns to ARMED. Playback loops until iAbort.
- Not defined: the sequence ends in DONE as above.

Decomposition:
- Package ext_code_pkg holds:
  - CODE_W, DEPTH, IDX_W defaults
  - state typedef enum {IDLE, ARMED, ACTIVE, DONE}
- Sub-module ext_code_trig_sync: SYNC_STAGES synchronizer plus edge detector. Outputs are level, rise and fall.

Test Plan:
1. Write table[k]=32'hA000_000k for k=0..7, iStart_idx=3, arm, apply 4 trigger pulses of 5 cycles each → oCode shows 0xA0000003, 02, 01, 00 during each pulse, 0 between pulses. oDone pulses after the 4th fall; state is DONE.
2. Sample iTrigger high at edge N → oCode valid at edge N+2 and zero again at M+2, where M is the first edge sampling it low.
3. Arm with start index 5, write during ARMED → table unchanged, oWr_err=1. Re-arm → oWr_err=0.
4. Assert iAbort mid-pulse in ACTIVE → next cycle oCode=0, state IDLE. Further triggers set oTrig_ovr=1 and oCode stays 0.
5. Assert iRst_n low mid-sequence → immediately oCode=0, oArmed=0, all entries read back 0 after re-arm.
6. With EXT_CODE_LOOP_EN, start index 1 and 5 pulses → codes 01, 00, 01, 00, 01, with oDone pulsing twice.
